ps2_host_fifo: RTL and testbench

Parametrised PS/2 host port: the next generation of our PS/2 controller, with configurable sample window, an RX byte FIFO, parity/framing error reporting, TX acknowledge checking and a frame watchdog. It sits between the open-drain PS/2 pins and the slow-I/O fabric. It exposes valid/ready streams instead of toggle handshakes, so several instances (keyboard, mouse) can be placed side by side.

---
 rtl/ps2_host_fifo.sv | 234 +++++++++++++++++++++++
 tb/tb_ps2_host_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_fifo.sv
// ps2_host_fifo -- PS/2 host port with majority-filtered pin sampling, an RX
// byte FIFO (first-word-fall-through), RX error reporting, host-to-device
// transmit with ack check, and a per-frame watchdog.
//
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   ps2_clock, ps2_data  open-drain pins, driven 0 or z only
//   rx_data/rx_valid/rx_ready/rx_level   RX FIFO stream and occupancy
//   tx_data/tx_valid/tx_ready            transmit request stream
//   err_parity, err_frame, err_overflow, tx_nack   one-cycle event pulses
module ps2_host_fifo #(
  parameter  int SAMPLE_BITS     = 10,
  parameter  int RX_DEPTH        = 8,
  parameter  int INHIBIT_WINDOWS = 10,
  parameter  int TIMEOUT_WINDOWS = 32,
  localparam int LW              = $clog2(RX_DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  inout  wire           ps2_clock,
  inout  wire           ps2_data,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic [LW-1:0] rx_level,
  input  logic [7:0]    tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic          err_parity,
  output logic          err_frame,
  output logic          err_overflow,
  output logic          tx_nack
);
  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = SAMPLE_BITS + 1;
  localparam int WW = $clog2(TIMEOUT_WINDOWS);
  localparam int IW = $clog2(INHIBIT_WINDOWS + 1);
  localparam logic [CW-1:0] HALF   = CW'(2 ** (SAMPLE_BITS - 1));
  localparam logic [WW-1:0] WD_M1  = WW'(TIMEOUT_WINDOWS - 1);
  localparam logic [IW-1:0] INH_N  = IW'(INHIBIT_WINDOWS);
  localparam logic [IW-1:0] INH_M1 = IW'(INHIBIT_WINDOWS - 1);
  localparam logic [LW-1:0] FULL   = LW'(RX_DEPTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RX   = 3'd1;
  localparam logic [2:0] S_TXI  = 3'd2;
  localparam logic [2:0] S_TXB  = 3'd3;
  localparam logic [2:0] S_TXA  = 3'd4;

  // ---------------------------------------------------------------- sampling
  logic [1:0]             clk_sync_q, dat_sync_q;
  logic [SAMPLE_BITS-1:0] win_q;
  logic [CW-1:0]          ccnt_q, dcnt_q, csum, dsum;
  logic                   fclk_q, clk_f, dat_f, win_end, fall;

  assign win_end = &win_q;
  assign csum    = ccnt_q + CW'(clk_sync_q[1]);
  assign dsum    = dcnt_q + CW'(dat_sync_q[1]);
  assign clk_f   = csum >= HALF;
  assign dat_f   = dsum >= HALF;
  assign fall    = win_end & fclk_q & ~clk_f;

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      win_q      <= '0;
      ccnt_q     <= '0;
      dcnt_q     <= '0;
      fclk_q     <= 1'b1;   // idle line is high: no false edge out of reset
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clock};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      win_q      <= win_q + 1'b1;
      if (win_end) begin
        ccnt_q <= '0;
        dcnt_q <= '0;
        fclk_q <= clk_f;
      end else begin
        ccnt_q <= csum;
        dcnt_q <= dsum;
      end
    end
  end

  // ---------------------------------------------------------------- FSM
  logic [2:0]    state_q, state_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    sr_q, sr_d;
  logic          par_q, par_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [IW-1:0] inh_q, inh_d;
  logic          drv_clk_q, drv_clk_d, drv_dat_q, drv_dat_d;
  logic          eper_q, eper_d, efrm_q, efrm_d, eovf_q, eovf_d, nack_q, nack_d;
  logic          push, pop, full, wr;

  assign tx_ready = (state_q == S_IDLE) & ~reset;

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    sr_d      = sr_q;
    par_d     = par_q;
    inh_d     = inh_q;
    drv_clk_d = drv_clk_q;
    drv_dat_d = drv_dat_q;
    eper_d    = 1'b0;
    efrm_d    = 1'b0;
    nack_d    = 1'b0;
    push      = 1'b0;
    // watchdog only runs while waiting on device clock edges
    if (fall || state_q == S_IDLE || state_q == S_TXI) wd_d = '0;
    else if (win_end)                                  wd_d = wd_q + 1'b1;
    else                                               wd_d = wd_q;

    case (state_q)
      S_IDLE: begin
        bit_d = '0;
        // a start edge beats a same-cycle transmit request
        if (fall && !dat_f) begin
          state_d = S_RX;
        end else if (tx_valid && tx_ready) begin
          state_d   = S_TXI;
          sr_d      = tx_data;
          inh_d     = '0;
          drv_clk_d = 1'b1;
        end
      end
      S_RX: if (fall) begin
        bit_d = bit_q + 4'd1;
        if (bit_q < 4'd8)       sr_d  = {dat_f, sr_q[7:1]};
        else if (bit_q == 4'd8) par_d = dat_f;
        else begin
          state_d = S_IDLE;
          eper_d  = ~(^{sr_q, par_q});
          efrm_d  = ~dat_f;
          push    = (^{sr_q, par_q}) & dat_f;
        end
      end
      // inh_q == 0 is the partial window of acceptance; the following
      // INHIBIT_WINDOWS windows are full, the last one carrying the start bit
      S_TXI: if (win_end) begin
        inh_d = inh_q + 1'b1;
        if (inh_q == INH_M1) drv_dat_d = 1'b1;
        if (inh_q == INH_N) begin
          drv_clk_d = 1'b0;
          bit_d     = '0;
          state_d   = S_TXB;
        end
      end
      S_TXB: if (fall) begin
        bit_d = bit_q + 4'd1;
        if (bit_q < 4'd8)       drv_dat_d = ~sr_q[bit_q[2:0]];
        else if (bit_q == 4'd8) drv_dat_d = ^sr_q;   // odd parity bit is ~^sr_q
        else begin
          drv_dat_d = 1'b0;                            // stop bit: released
          state_d   = S_TXA;
        end
      end
      S_TXA: if (fall) begin
        state_d = S_IDLE;
        nack_d  = dat_f;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && state_q != S_TXI && win_end && !fall && wd_q == WD_M1) begin
      state_d   = S_IDLE;
      drv_clk_d = 1'b0;
      drv_dat_d = 1'b0;
      efrm_d    = (state_q == S_RX);
      nack_d    = (state_q != S_RX);
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    mem_q [RX_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] cnt_q;

  assign rx_valid = cnt_q != '0;
  assign rx_level = cnt_q;
  assign rx_data  = mem_q[rptr_q];
  assign pop      = rx_valid & rx_ready;
  assign full     = cnt_q == FULL;
  assign wr       = push & (~full | pop);   // a same-cycle pop frees the slot
  assign eovf_d   = push & full & ~pop;

  always_ff @(posedge clock) if (wr) mem_q[wptr_q] <= sr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bit_q     <= '0;
      sr_q      <= '0;
      par_q     <= 1'b0;
      wd_q      <= '0;
      inh_q     <= '0;
      drv_clk_q <= 1'b0;
      drv_dat_q <= 1'b0;
      eper_q    <= 1'b0;
      efrm_q    <= 1'b0;
      eovf_q    <= 1'b0;
      nack_q    <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      sr_q      <= sr_d;
      par_q     <= par_d;
      wd_q      <= wd_d;
      inh_q     <= inh_d;
      drv_clk_q <= drv_clk_d;
      drv_dat_q <= drv_dat_d;
      eper_q    <= eper_d;
      efrm_q    <= efrm_d;
      eovf_q    <= eovf_d;
      nack_q    <= nack_d;
      if (wr)  wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      cnt_q     <= cnt_q + LW'(wr) - LW'(pop);
    end
  end

  assign err_parity   = eper_q;
  assign err_frame    = efrm_q;
  assign err_overflow = eovf_q;
  assign tx_nack      = nack_q;

  assign ps2_clock = drv_clk_q ? 1'b0 : 1'bz;
  assign ps2_data  = drv_dat_q ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_ps2_host_fifo.sv
// tb_ps2_host_fifo -- bench for ps2_host_fifo with a behavioural PS/2 device
// on pulled-up open-drain lines and a byte scoreboard for the RX FIFO.
module tb_ps2_host_fifo;
  localparam int SB    = 4;
  localparam int DEPTH = 2;
  localparam int INH   = 10;
  localparam int TMO   = 32;
  localparam int WIN   = 1 << SB;
  localparam int HALF  = 12 * WIN;   // device half-period; full bit stays inside the watchdog

  logic       clock = 1'b0, reset = 1'b1;
  logic       rx_ready = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic [1:0] rx_level;
  logic       rx_valid, tx_ready, err_parity, err_frame, err_overflow, tx_nack;
  logic       dev_clk_lo = 1'b0, dev_dat_lo = 1'b0;
  wire        ps2_clk_w, ps2_dat_w;

  pullup (ps2_clk_w);
  pullup (ps2_dat_w);
  assign ps2_clk_w = dev_clk_lo ? 1'b0 : 1'bz;
  assign ps2_dat_w = dev_dat_lo ? 1'b0 : 1'bz;

  always #5 clock = ~clock;

  ps2_host_fifo #(.SAMPLE_BITS(SB), .RX_DEPTH(DEPTH), .INHIBIT_WINDOWS(INH),
                  .TIMEOUT_WINDOWS(TMO)) dut (
    .clock(clock), .reset(reset), .ps2_clock(ps2_clk_w), .ps2_data(ps2_dat_w),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_level(rx_level),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .err_parity(err_parity), .err_frame(err_frame), .err_overflow(err_overflow),
    .tx_nack(tx_nack));

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // pulse monitors
  int   n_par = 0, n_frm = 0, n_ovf = 0, n_nack = 0, n_long = 0;
  logic p_par = 1'b0, p_frm = 1'b0, p_ovf = 1'b0, p_nack = 1'b0, rdy_at_frm = 1'b0;
  always @(negedge clock) begin
    if (err_parity)   n_par  <= n_par + 1;
    if (err_frame)    n_frm  <= n_frm + 1;
    if (err_overflow) n_ovf  <= n_ovf + 1;
    if (tx_nack)      n_nack <= n_nack + 1;
    if (err_frame)    rdy_at_frm <= tx_ready;
    if ((err_parity & p_par) | (err_frame & p_frm) | (err_overflow & p_ovf) | (tx_nack & p_nack))
      n_long <= n_long + 1;
    p_par <= err_parity; p_frm <= err_frame; p_ovf <= err_overflow; p_nack <= tx_nack;
  end

  logic [7:0] exp_q[$];
  int exp_par = 0, exp_frm = 0, exp_ovf = 0;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic dev_bit(input logic b);
    dev_dat_lo = ~b;
    wait_clk(HALF);
    dev_clk_lo = 1'b1;
    wait_clk(HALF);
    dev_clk_lo = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic par_flip, input logic stop);
    logic p;
    p = (~^d) ^ par_flip;
    if (par_flip) exp_par++;
    if (!stop)    exp_frm++;
    if (!par_flip && stop) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else                      exp_ovf++;
    end
    dev_bit(1'b0);
    for (int i = 0; i < 8; i++) dev_bit(d[i]);
    dev_bit(p);
    dev_bit(stop);
    dev_dat_lo = 1'b0;
    wait_clk(4 * WIN);
    chk("rx_par_cnt", n_par, exp_par);
    chk("rx_frm_cnt", n_frm, exp_frm);
    chk("rx_ovf_cnt", n_ovf, exp_ovf);
    chk("rx_level", {30'd0, rx_level}, exp_q.size());
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    if (rx_valid && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk(tag, rx_data, e);
      rx_ready = 1'b1;
      @(negedge clock);
      rx_ready = 1'b0;
    end else begin
      chk({tag, "_valid"}, rx_valid, exp_q.size() != 0);
    end
  endtask

  task automatic do_tx(input logic [7:0] d, input logic ack);
    logic [10:0] obs, expv;
    int t, nk0;
    nk0  = n_nack;
    expv = {1'b1, ~^d, d, 1'b0};
    obs  = '0;
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    chk("tx_ready_fall", tx_ready, 0);
    t = 0;
    while (ps2_clk_w === 1'b0 && t < 20 * WIN) begin @(negedge clock); t++; end
    chk("tx_inhibit_len", (t >= INH * WIN) && (t <= (INH + 1) * WIN + 2), 1);
    obs[0] = ps2_dat_w;
    for (int k = 1; k <= 10; k++) begin
      wait_clk(HALF);
      dev_clk_lo = 1'b1;
      wait_clk(HALF);
      obs[k] = ps2_dat_w;
      dev_clk_lo = 1'b0;
    end
    wait_clk(HALF);
    dev_dat_lo = ack;
    dev_clk_lo = 1'b1;
    wait_clk(HALF);
    dev_clk_lo = 1'b0;
    wait_clk(WIN);
    dev_dat_lo = 1'b0;
    wait_clk(4 * WIN);
    chk("tx_bits", obs, expv);
    chk("tx_nack_cnt", n_nack - nk0, !ack);
    chk("tx_ready_back", tx_ready, 1);
  endtask

  initial begin
    int t, f0;
    // reset state
    wait_clk(3);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_level", rx_level, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_pins", {ps2_clk_w, ps2_dat_w}, 2'b11);
    chk("rst_errs", {err_parity, err_frame, err_overflow, tx_nack}, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_tx_ready", tx_ready, 1);

    // good byte, then pop
    send_rx(8'h1C, 1'b0, 1'b1);
    pop_chk("rx_1c");
    chk("level_after_pop", rx_level, 0);

    // parity error, then parity+stop error
    send_rx(8'h1C, 1'b1, 1'b1);
    send_rx(8'hA5, 1'b1, 1'b0);

    // overflow with a two-entry FIFO
    send_rx(8'h01, 1'b0, 1'b1);
    send_rx(8'h02, 1'b0, 1'b1);
    send_rx(8'h03, 1'b0, 1'b1);
    pop_chk("rx_01");
    pop_chk("rx_02");
    chk("fifo_drained", rx_valid, 0);

    // transmit with ack, then without
    do_tx(8'hF4, 1'b1);
    do_tx(8'hF4, 1'b0);

    // device stops after four bits: watchdog aborts the frame
    f0 = n_frm;
    exp_frm++;
    dev_bit(1'b0); dev_bit(1'b1); dev_bit(1'b0); dev_bit(1'b1);
    dev_dat_lo = 1'b0;
    t = 0;
    while (n_frm == f0 && t < 40 * WIN) begin @(negedge clock); t++; end
    chk("tmo_frm_cnt", n_frm, exp_frm);
    chk("tmo_delay", (HALF + t >= TMO * WIN) && (HALF + t <= (TMO + 3) * WIN), 1);
    chk("tmo_ready_at_pulse", rdy_at_frm, 1);
    chk("tmo_level", rx_level, 0);
    chk("tmo_par_cnt", n_par, exp_par);

    // reset during the inhibit phase releases both lines next cycle
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    t = 0;
    while (ps2_dat_w !== 1'b0 && t < 20 * WIN) begin @(negedge clock); t++; end
    chk("rst_tx_start_bit", {ps2_clk_w, ps2_dat_w}, 2'b00);
    f0 = n_nack;
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_tx_pins", {ps2_clk_w, ps2_dat_w}, 2'b11);
    @(negedge clock);
    chk("rst_tx_ready_low", tx_ready, 0);
    reset = 1'b0;
    wait_clk(4 * WIN);
    chk("rst_tx_ready_back", tx_ready, 1);
    chk("rst_no_nack", n_nack, f0);
    chk("pulse_width", n_long, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
